pipe_spawner: RTL
=================

# pipe_spawner

Obstacle generator for the Flappy Bird datapath, directly downstream of the 10-bit LFSR random source. Once per video frame it scrolls all live pipes left. It retires pipes that reach the left edge, spawns a new pipe at the right edge at a fixed pixel spacing, and derives each new pipe's gap height from the LFSR value, pulsing the LFSR enable exactly once per spawn. Its outputs feed the pipe renderer and the collision/score logic.

## Interface
- NUM_PIPES, 5, number of pipe slots
- SCREEN_W, 640, spawn x coordinate (pixels)
- PIPE_W, 32, pipe width (pixels)
- SCROLL_STEP, 2, pixels scrolled per frame
- SPAWN_GAP, 160, scrolled pixels between spawns
- GAP_MIN, 40, minimum gap_top (pixels)
- BIRD_X, 160, bird column used for score crossing
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame
- run  in  1  game active level
- rand_num  in  10  current LFSR value
- rand_en  out  1  LFSR advance pulse, one cycle per spawn
- pipe_valid  out  NUM_PIPES  slot occupied
- pipe_x  out  NUM_PIPES*10  packed per-slot left x, slot i at [10i+9:10i]
- pipe_gap_top  out  NUM_PIPES*10  packed per-slot gap top y
- score_pulse  out  1  one-cycle pulse when a pipe's right edge passes BIRD_X

## Operation
- FSM states: IDLE, WAIT, SCROLL, SPAWN.
  - IDLE → WAIT when run=1.
  - WAIT → SCROLL on frame_tick.
  - SCROLL → SPAWN unconditionally.
  - SPAWN → WAIT unconditionally.
  - Any state → IDLE when run=0.
- frame_tick is ignored outside WAIT. Frames are far longer than 3 cycles, so ticks cannot collide.
- SCROLL, per valid slot:
  - If x < SCROLL_STEP: clear valid (retire).
  - Otherwise: x ← x − SCROLL_STEP.
  - spawn_cnt ← min(spawn_cnt + SCROLL_STEP, 1023). spawn_cnt is 10 bits, saturating.
  - score_pulse is registered high for one cycle if any slot satisfies old x+PIPE_W > BIRD_X and new x+PIPE_W ≤ BIRD_X. This is 11-bit arithmetic, no wrap. At most one pulse per frame.
- SPAWN, when spawn_cnt ≥ SPAWN_GAP and a free slot exists:
  - Load the lowest-index free slot with valid=1, x=SCREEN_W, gap_top = GAP_MIN + rand_num[7:0] (10-bit result).
  - spawn_cnt ← spawn_cnt − SPAWN_GAP.
  - rand_en = 1 for this cycle.
- SPAWN with no free slot: no load, rand_en=0, spawn_cnt held. The spawn retries on subsequent frames.
- Slots freed in SCROLL are available in the SPAWN of the same frame.
- gap_top never exceeds GAP_MIN+255. The renderer owns the gap height.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - spawn_cnt = SPAWN_GAP − SCROLL_STEP, so the first frame spawns immediately.
- run=0 in any state: next edge gives IDLE, all valid cleared, spawn_cnt back to its reset value. x and gap_top are held; they are don't-care while invalid.
- frame_tick high at cycle t in WAIT:
  - SCROLL at t+1.
  - Scrolled x and score_pulse visible at t+2.
  - SPAWN at t+2, rand_en high during t+2.
  - New slot visible at t+3.
  - WAIT at t+3.
- rand_num is sampled on the same edge the LFSR advances. Each spawn uses the pre-advance value.
- rand_en is combinational from state plus spawn condition. No other cycle asserts it.

## Structure
- pipe_pkg holds:
  - the state enum
  - the 10-bit coordinate typedef
  - the default parameter constants
- Sub-module pipe_slot, instantiated NUM_PIPES times. Each instance contains:
  - the x, gap_top and valid registers
  - inputs: scroll, clear, load with load data
  - outputs: free and crossed (score crossing)
- Top level holds:
  - the FSM
  - spawn_cnt
  - the priority free-slot encoder
  - the OR-reduce of crossed into score_pulse

## Test plan
- Reset held 3 cycles, run=0 → all outputs 0. 20 frame_ticks with run=0 → no change, rand_en never high.
- run=1, rand_num=10'h000, one frame_tick at t → rand_en high only at t+2. Slot 0 valid at t+3 with x=640, gap_top=40.
- Second spawn with rand_num=10'h3FF → slot 1 spawns exactly 80 ticks after the first, gap_top=295. Slot 0 x=480 at that time.
- Single pipe:
  - score_pulse once, on the tick that brings x to 128 (tick 256 after spawn).
  - Retired on tick 321, when x goes from 0 to invalid.
  - Over 5 consecutive spawns, the slot-0 spawn at tick 320 reuses no live slot, and at most 5 slots are ever valid.
- NUM_PIPES=2 override → third spawn suppressed with rand_en low. The spawn fires on the first frame after slot 0 retires.
- Mid-operation: run dropped during SCROLL with 3 valid pipes → next cycle IDLE, pipe_valid=0, no rand_en. Re-raising run plus one tick spawns slot 0 immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, default constants and helpers for the pipe spawner
package pipe_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SCROLL,
        ST_SPAWN
    } state_t;

    localparam int DEF_NUM_PIPES   = 5;
    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_PIPE_W      = 32;
    localparam int DEF_SCROLL_STEP = 2;
    localparam int DEF_SPAWN_GAP   = 160;
    localparam int DEF_GAP_MIN     = 40;
    localparam int DEF_BIRD_X      = 160;

    function automatic coord_t sat_add(input coord_t a, input coord_t b);
        logic [10:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[10] ? 10'h3FF : w_sum[9:0];
    endfunction

endpackage

// File: rtl/pipe_spawner_if.sv
// rtl/pipe_spawner_if.sv - frame/LFSR inputs and pipe outputs of the pipe spawner
interface pipe_spawner_if #(
    parameter int NUM_PIPES = 5
);
    logic                      frame_tick;
    logic                      run;
    logic [9:0]                rand_num;
    logic                      rand_en;
    logic [NUM_PIPES-1:0]      pipe_valid;
    logic [NUM_PIPES*10-1:0]   pipe_x;
    logic [NUM_PIPES*10-1:0]   pipe_gap_top;
    logic                      score_pulse;

    modport slave (
        input  frame_tick, run, rand_num,
        output rand_en, pipe_valid, pipe_x, pipe_gap_top, score_pulse
    );

    modport master (
        output frame_tick, run, rand_num,
        input  rand_en, pipe_valid, pipe_x, pipe_gap_top, score_pulse
    );
endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipe slot: position, gap, occupancy and score-crossing detect
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int PIPE_W      = DEF_PIPE_W,
    parameter int SCROLL_STEP = DEF_SCROLL_STEP,
    parameter int BIRD_X      = DEF_BIRD_X
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_scroll,
    input  logic   i_clear,
    input  logic   i_load,
    input  coord_t i_load_x,
    input  coord_t i_load_gap,
    output logic   o_valid,
    output coord_t o_x,
    output coord_t o_gap_top,
    output logic   o_free,
    output logic   o_crossed
);

    logic        r_valid;
    coord_t      r_x;
    coord_t      r_gap_top;
    logic        w_retire;
    coord_t      w_new_x;
    logic [10:0] w_old_right;
    logic [10:0] w_new_right;

    assign w_retire    = r_valid && (r_x < coord_t'(SCROLL_STEP));
    assign w_new_x     = r_x - coord_t'(SCROLL_STEP);
    // 11-bit right edges so x near 1023 cannot wrap past the bird column
    assign w_old_right = {1'b0, r_x} + 11'(PIPE_W);
    assign w_new_right = {1'b0, w_new_x} + 11'(PIPE_W);
    assign o_crossed   = r_valid && !w_retire &&
                         (w_old_right > 11'(BIRD_X)) && (w_new_right <= 11'(BIRD_X));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_gap_top <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_x       <= i_load_x;
            r_gap_top <= i_load_gap;
        end else if (i_scroll && r_valid) begin
            if (w_retire) begin
                r_valid <= 1'b0;
            end else begin
                r_x <= w_new_x;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_x       = r_x;
    assign o_gap_top = r_gap_top;
    assign o_free    = !r_valid;

endmodule

// File: rtl/pipe_spawner.sv
// rtl/pipe_spawner.sv - per-frame pipe scroll, retire and LFSR-driven spawn control
module pipe_spawner
    import pipe_pkg::*;
#(
    parameter int NUM_PIPES   = DEF_NUM_PIPES,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int PIPE_W      = DEF_PIPE_W,
    parameter int SCROLL_STEP = DEF_SCROLL_STEP,
    parameter int SPAWN_GAP   = DEF_SPAWN_GAP,
    parameter int GAP_MIN     = DEF_GAP_MIN,
    parameter int BIRD_X      = DEF_BIRD_X
) (
    input  logic           clk,
    input  logic           reset,
    pipe_spawner_if.slave  bus
);

    localparam coord_t CNT_RESET = coord_t'(SPAWN_GAP - SCROLL_STEP);

    state_t                  r_state;
    state_t                  w_next_state;
    coord_t                  r_spawn_cnt;
    logic                    r_score_pulse;
    logic                    w_scroll;
    logic                    w_clear;
    logic                    w_do_spawn;
    coord_t                  w_gap;
    logic [NUM_PIPES-1:0]    w_valid;
    logic [NUM_PIPES-1:0]    w_free;
    logic [NUM_PIPES-1:0]    w_free_lowest;
    logic [NUM_PIPES-1:0]    w_load_oh;
    logic [NUM_PIPES-1:0]    w_crossed;
    coord_t                  w_x       [NUM_PIPES];
    coord_t                  w_gap_top [NUM_PIPES];
    logic [NUM_PIPES*10-1:0] w_x_packed;
    logic [NUM_PIPES*10-1:0] w_gap_packed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!bus.run) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_next_state = ST_WAIT;
                ST_WAIT:   if (bus.frame_tick) w_next_state = ST_SCROLL;
                ST_SCROLL: w_next_state = ST_SPAWN;
                ST_SPAWN:  w_next_state = ST_WAIT;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    assign w_scroll      = (r_state == ST_SCROLL) && bus.run;
    assign w_clear       = !bus.run;
    // x & -x isolates the lowest set bit: lowest-index free slot wins
    assign w_free_lowest = w_free & (~w_free + 1'b1);
    assign w_do_spawn    = (r_state == ST_SPAWN) && bus.run &&
                           (r_spawn_cnt >= coord_t'(SPAWN_GAP)) && (|w_free);
    assign w_load_oh     = w_do_spawn ? w_free_lowest : '0;
    assign w_gap         = coord_t'(GAP_MIN) + {2'b00, bus.rand_num[7:0]};

    always_ff @(posedge clk) begin
        if (reset || !bus.run) begin
            r_spawn_cnt <= CNT_RESET;
        end else if (r_state == ST_SCROLL) begin
            r_spawn_cnt <= sat_add(r_spawn_cnt, coord_t'(SCROLL_STEP));
        end else if (w_do_spawn) begin
            r_spawn_cnt <= r_spawn_cnt - coord_t'(SPAWN_GAP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_score_pulse <= 1'b0;
        end else begin
            r_score_pulse <= w_scroll && (|w_crossed);
        end
    end

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
        pipe_slot #(
            .PIPE_W      (PIPE_W),
            .SCROLL_STEP (SCROLL_STEP),
            .BIRD_X      (BIRD_X)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .i_scroll   (w_scroll),
            .i_clear    (w_clear),
            .i_load     (w_load_oh[gi]),
            .i_load_x   (coord_t'(SCREEN_W)),
            .i_load_gap (w_gap),
            .o_valid    (w_valid[gi]),
            .o_x        (w_x[gi]),
            .o_gap_top  (w_gap_top[gi]),
            .o_free     (w_free[gi]),
            .o_crossed  (w_crossed[gi])
        );
    end

    always_comb begin
        w_x_packed   = '0;
        w_gap_packed = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            w_x_packed[10*i +: 10]   = w_x[i];
            w_gap_packed[10*i +: 10] = w_gap_top[i];
        end
    end

    assign bus.rand_en      = w_do_spawn;
    assign bus.pipe_valid   = w_valid;
    assign bus.pipe_x       = w_x_packed;
    assign bus.pipe_gap_top = w_gap_packed;
    assign bus.score_pulse  = r_score_pulse;

endmodule
